// File: rtl/pwm_sample_decoder.sv
// PWM-to-sample front end: measures period and high time of an external PWM line,
// recovers the encoded sample and reports lock, period errors and stuck-line conditions.
module pwm_sample_decoder #(
  parameter int width   = 12,
  parameter int PERIOD  = 4096,
  parameter int TOL     = 2,
  parameter int TIMEOUT = 8192
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [width-1:0] sample,
  output logic             sample_valid,
  output logic             lock,
  output logic             stuck,
  output logic             err_period
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] P_MIN     = CW'((PERIOD > TOL) ? PERIOD - TOL : 0);
  localparam logic [CW-1:0] P_MAX     = CW'(PERIOD + TOL);
  localparam int unsigned   SAMPLE_MAX = (2 ** width) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_e;

  state_e          state_q;
  logic            sync1_q;
  logic            pwm_s_q;
  logic            pwm_d_q;
  logic [CW-1:0]   period_cnt_q;
  logic [CW-1:0]   period_cnt_d;
  logic [CW-1:0]   high_cnt_q;
  logic [CW-1:0]   high_cnt_d;
  logic            rise;
  logic            fall;
  logic            restart;
  logic            timeout;
  logic            in_tol;
  logic            go_stuck;
  logic [width-1:0] sat_sample;

  assign rise = pwm_s_q & ~pwm_d_q;
  assign fall = ~pwm_s_q & pwm_d_q;

  // Counters re-anchor on any edge while no phase reference is held, but only on
  // rising edges while measuring, so a period spans rise to rise.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    restart = 1'b0;
    unique case (state_q)
      IDLE, STUCK: restart = rise | fall;
      MEASURE:     restart = rise;
      default:     restart = 1'b0;
    endcase
  end

  assign timeout      = (period_cnt_q == TIMEOUT_C);
  assign period_cnt_d = restart ? CW'(1)
                      : timeout ? period_cnt_q
                      : period_cnt_q + CW'(1);
  assign high_cnt_d   = restart ? CW'(pwm_s_q)
                      : (high_cnt_q == TIMEOUT_C) ? high_cnt_q
                      : high_cnt_q + CW'(pwm_s_q);
  assign in_tol       = (period_cnt_q >= P_MIN) && (period_cnt_q <= P_MAX);
  // An edge arriving in the timeout cycle wins over the stuck declaration.
  assign go_stuck     = timeout && !restart && (state_q != STUCK);
  assign sat_sample   = (32'(high_cnt_q) > SAMPLE_MAX) ? {width{1'b1}} : width'(high_cnt_q);

  // NOTE: pwm_in is asynchronous, so it passes two flops before any edge logic looks at it.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      pwm_s_q      <= 1'b0;
      pwm_d_q      <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q      <= pwm_in;
      pwm_s_q      <= sync1_q;
      pwm_d_q      <= pwm_s_q;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sample       <= '0;
      sample_valid <= 1'b0;
      lock         <= 1'b0;
      stuck        <= 1'b0;
      err_period   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      err_period   <= 1'b0;
      if (go_stuck) begin
        state_q      <= STUCK;
        stuck        <= 1'b1;
        lock         <= 1'b0;
        sample_valid <= 1'b1;
        sample       <= {width{pwm_s_q}};
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise) state_q <= MEASURE;
          end
          MEASURE: begin
            if (rise) begin
              if (in_tol) begin
                sample       <= sat_sample;
                sample_valid <= 1'b1;
                lock         <= 1'b1;
              end else begin
                err_period <= 1'b1;
                lock       <= 1'b0;
              end
            end
          end
          STUCK: begin
            if (rise || fall) begin
              state_q <= rise ? MEASURE : IDLE;
              stuck   <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Bench for pwm_sample_decoder: pin-level waveforms scored every cycle against a
// model that works from the pin history (rise times, high-cycle sums, timeouts).
module tb_pwm_sample_decoder;

  localparam int W       = 12;
  localparam int PERIOD  = 4096;
  localparam int TOL     = 2;
  localparam int TIMEOUT = 8192;
  localparam int SMAX    = (1 << W) - 1;
  localparam int MAXS    = 100000;
  localparam int LAT     = 3;

  logic         clk1   = 1'b0;
  logic         reset  = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] sample;
  logic         sample_valid;
  logic         lock;
  logic         stuck;
  logic         err_period;

  pwm_sample_decoder #(
    .width  (W),
    .PERIOD (PERIOD),
    .TOL    (TOL),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk1        (clk1),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .sample      (sample),
    .sample_valid(sample_valid),
    .lock        (lock),
    .stuck       (stuck),
    .err_period  (err_period)
  );

  always #5 clk1 = ~clk1;

  typedef enum int {NO_PHASE, PHASED, LINE_STUCK} line_mode_e;
  typedef enum int {EV_SAMPLE, EV_ERR, EV_STUCK, EV_UNSTUCK} ev_kind_e;
  typedef struct {
    int       due;
    ev_kind_e kind;
    int       val;
  } ev_t;
  typedef struct {
    bit lvl;
    int len;
  } seg_t;

  ev_t        pend[$];
  seg_t       segs[$];
  bit         pin_hist [MAXS];
  int         n = 0;
  line_mode_e mode = NO_PHASE;
  int         ref_t = 0;
  bit         rel_req = 1'b0;

  int e_sample = 0;
  bit e_valid  = 1'b0;
  bit e_lock   = 1'b0;
  bit e_stuck  = 1'b0;
  bit e_err    = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int valid_seen  = 0;
  int err_seen    = 0;

  function automatic int high_between(input int a, input int b);
    int s = 0;
    for (int j = a; j < b; j++) s += int'(pin_hist[j]);
    return s;
  endfunction

  task automatic schedule(input int m, input ev_kind_e k, input int v);
    ev_t e;
    e.due  = m + LAT;
    e.kind = k;
    e.val  = v;
    pend.push_back(e);
  endtask

  // Reference behaviour at pin step m; outputs appear LAT steps later.
  task automatic model_step(input int m);
    bit rise_e, fall_e;
    int el, p, h, d;
    rise_e = pin_hist[m] && !pin_hist[m-1];
    fall_e = !pin_hist[m] && pin_hist[m-1];
    el     = m - ref_t;
    case (mode)
      NO_PHASE: begin
        if (rise_e || fall_e) begin
          ref_t = m;
          if (rise_e) mode = PHASED;
        end else if (el == TIMEOUT) begin
          mode = LINE_STUCK;
          schedule(m, EV_STUCK, pin_hist[m] ? SMAX : 0);
        end
      end
      PHASED: begin
        if (rise_e) begin
          p = el;
          h = high_between(ref_t, m);
          ref_t = m;
          d = (p > PERIOD) ? p - PERIOD : PERIOD - p;
          if (d <= TOL) schedule(m, EV_SAMPLE, (h > SMAX) ? SMAX : h);
          else          schedule(m, EV_ERR, 0);
        end else if (el == TIMEOUT) begin
          mode = LINE_STUCK;
          schedule(m, EV_STUCK, pin_hist[m] ? SMAX : 0);
        end
      end
      default: begin
        if (rise_e || fall_e) begin
          ref_t = m;
          mode  = rise_e ? PHASED : NO_PHASE;
          schedule(m, EV_UNSTUCK, 0);
        end
      end
    endcase
  endtask

  task automatic apply_due();
    ev_t e;
    e_valid = 1'b0;
    e_err   = 1'b0;
    while (pend.size() > 0 && pend[0].due == n) begin
      e = pend.pop_front();
      case (e.kind)
        EV_SAMPLE: begin e_sample = e.val; e_valid = 1'b1; e_lock = 1'b1; end
        EV_ERR:    begin e_err = 1'b1; e_lock = 1'b0; end
        EV_STUCK:  begin e_sample = e.val; e_valid = 1'b1; e_lock = 1'b0; e_stuck = 1'b1; end
        default:   e_stuck = 1'b0;
      endcase
    end
  endtask

  // One clock step: sample DUT and model at the falling edge, then drive the pin.
  task automatic tick(input bit v, output logic [W+3:0] got, output logic [W+3:0] want);
    @(negedge clk1);
    apply_due();
    got  = {sample, sample_valid, lock, stuck, err_period};
    want = {W'(e_sample), e_valid, e_lock, e_stuck, e_err};
    if (sample_valid === 1'b1) valid_seen++;
    if (err_period === 1'b1) err_seen++;
    if (rel_req) begin
      reset           = 1'b0;
      rel_req         = 1'b0;
      pin_hist[n-1]   = 1'b0;
      pin_hist[n-2]   = 1'b0;
      ref_t           = n - 2;
      mode            = NO_PHASE;
    end
    pwm_in      = v;
    pin_hist[n] = v;
    if (!reset) model_step(n);
    n++;
  endtask

  task automatic assert_reset();
    #2 reset = 1'b1;
    pend.delete();
    e_sample = 0;
    e_lock   = 1'b0;
    e_stuck  = 1'b0;
    e_valid  = 1'b0;
    e_err    = 1'b0;
    mode     = NO_PHASE;
  endtask

  task automatic add_seg(input bit l, input int len);
    seg_t s;
    s.lvl = l;
    s.len = len;
    segs.push_back(s);
  endtask

  task automatic add_period(input int high, input int len);
    add_seg(1'b1, high);
    add_seg(1'b0, len - high);
  endtask

  task automatic test_reset();
    logic [W+3:0] got, want;
    valid_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, got, want);
      vectors++;
      if (got !== {(W+4){1'b0}}) begin
        miscompares++;
        $display("FAIL reset_hold step %0d: got %h want %h", n - 1, got, {(W+4){1'b0}});
      end
    end
    rel_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_release step %0d: got %h want %h", n - 1, got, want);
      end
    end
  endtask

  task automatic test_lock_1024();
    logic [W+3:0] got, want;
    valid_seen = 0;
    err_seen   = 0;
    segs.delete();
    add_seg(1'b0, 10);
    for (int p = 0; p < 4; p++) add_period(1024, PERIOD);
    add_seg(1'b1, 4);
    foreach (segs[k])
      for (int i = 0; i < segs[k].len; i++) begin
        tick(segs[k].lvl, got, want);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL lock_1024 step %0d: got %h want %h", n - 1, got, want);
        end
      end
    vectors++;
    if (valid_seen !== 4 || err_seen !== 0 || sample !== W'(1024) || lock !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_1024_totals: valids=%0d errs=%0d sample=%0d lock=%b, want 4 0 1024 1",
               valid_seen, err_seen, sample, lock);
    end
  endtask

  task automatic test_full_scale_then_stuck_high();
    logic [W+3:0] got, want;
    valid_seen = 0;
    err_seen   = 0;
    segs.delete();
    add_seg(1'b1, PERIOD - 1 - 4);
    add_seg(1'b0, 1);
    add_seg(1'b1, TIMEOUT + 8);
    foreach (segs[k])
      for (int i = 0; i < segs[k].len; i++) begin
        tick(segs[k].lvl, got, want);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL stuck_high step %0d: got %h want %h", n - 1, got, want);
        end
      end
    vectors++;
    if (valid_seen !== 2 || err_seen !== 0 || stuck !== 1'b1 || sample !== W'(SMAX) || lock !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_high_totals: valids=%0d errs=%0d stuck=%b sample=%0d lock=%b, want 2 0 1 %0d 0",
               valid_seen, err_seen, stuck, sample, lock, SMAX);
    end
  endtask

  task automatic test_stuck_low_from_reset();
    logic [W+3:0] got, want;
    valid_seen = 0;
    err_seen   = 0;
    assert_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL stuck_low_reset step %0d: got %h want %h", n - 1, got, want);
      end
    end
    rel_req = 1'b1;
    segs.delete();
    add_seg(1'b0, TIMEOUT + 8);
    add_period(2048, PERIOD);
    add_seg(1'b1, 4);
    foreach (segs[k])
      for (int i = 0; i < segs[k].len; i++) begin
        tick(segs[k].lvl, got, want);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL stuck_low step %0d: got %h want %h", n - 1, got, want);
        end
      end
    vectors++;
    if (valid_seen !== 2 || err_seen !== 0 || stuck !== 1'b0 || sample !== W'(2048) || lock !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_low_totals: valids=%0d errs=%0d stuck=%b sample=%0d lock=%b, want 2 0 0 2048 1",
               valid_seen, err_seen, stuck, sample, lock);
    end
  endtask

  task automatic test_tolerance();
    logic [W+3:0] got, want;
    valid_seen = 0;
    err_seen   = 0;
    segs.delete();
    add_seg(1'b1, 2048 - 4);
    add_seg(1'b0, 4100 - 2048);
    add_period(2048, 4097);
    add_seg(1'b1, 4);
    foreach (segs[k])
      for (int i = 0; i < segs[k].len; i++) begin
        tick(segs[k].lvl, got, want);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL tolerance step %0d: got %h want %h", n - 1, got, want);
        end
      end
    vectors++;
    if (valid_seen !== 1 || err_seen !== 1 || sample !== W'(2048) || lock !== 1'b1) begin
      miscompares++;
      $display("FAIL tolerance_totals: valids=%0d errs=%0d sample=%0d lock=%b, want 1 1 2048 1",
               valid_seen, err_seen, sample, lock);
    end
  endtask

  task automatic test_glitch();
    logic [W+3:0] got, want;
    valid_seen = 0;
    err_seen   = 0;
    segs.delete();
    add_seg(1'b1, 2048 - 4);
    add_seg(1'b0, 900);
    add_seg(1'b1, 5);
    add_seg(1'b0, PERIOD - 2048 - 905);
    add_period(2048, PERIOD);
    add_seg(1'b1, 4);
    foreach (segs[k])
      for (int i = 0; i < segs[k].len; i++) begin
        tick(segs[k].lvl, got, want);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL glitch step %0d: got %h want %h", n - 1, got, want);
        end
      end
    vectors++;
    if (valid_seen !== 1 || err_seen !== 2 || sample !== W'(2048) || lock !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_totals: valids=%0d errs=%0d sample=%0d lock=%b, want 1 2 2048 1",
               valid_seen, err_seen, sample, lock);
    end
  endtask

  task automatic test_reset_while_locked();
    logic [W+3:0] got, want;
    valid_seen = 0;
    err_seen   = 0;
    segs.delete();
    add_seg(1'b1, 1000);
    foreach (segs[k])
      for (int i = 0; i < segs[k].len; i++) begin
        tick(segs[k].lvl, got, want);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL reset_locked_pre step %0d: got %h want %h", n - 1, got, want);
        end
      end
    assert_reset();
    #1;
    got = {sample, sample_valid, lock, stuck, err_period};
    vectors++;
    if (got !== {(W+4){1'b0}}) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", got, {(W+4){1'b0}});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_locked_hold step %0d: got %h want %h", n - 1, got, want);
      end
    end
    rel_req = 1'b1;
    segs.delete();
    add_seg(1'b0, 100);
    add_period(2048, PERIOD);
    add_seg(1'b1, 4);
    foreach (segs[k])
      for (int i = 0; i < segs[k].len; i++) begin
        tick(segs[k].lvl, got, want);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL reset_locked_post step %0d: got %h want %h", n - 1, got, want);
        end
      end
    vectors++;
    if (valid_seen !== 1 || err_seen !== 0 || sample !== W'(2048) || lock !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_locked_totals: valids=%0d errs=%0d sample=%0d lock=%b, want 1 0 2048 1",
               valid_seen, err_seen, sample, lock);
    end
  endtask

  task automatic test_random_periods();
    logic [W+3:0] got, want;
    int len, high, ok;
    valid_seen = 0;
    err_seen   = 0;
    ok         = 0;
    segs.delete();
    add_seg(1'b1, 2048 - 4);
    add_seg(1'b0, PERIOD - 2048);
    for (int p = 0; p < 4; p++) begin
      len  = PERIOD - 4 + int'($urandom_range(0, 8));
      high = int'($urandom_range(1, len - 1));
      if (len >= PERIOD - TOL && len <= PERIOD + TOL) ok++;
      add_period(high, len);
    end
    add_seg(1'b1, 4);
    foreach (segs[k])
      for (int i = 0; i < segs[k].len; i++) begin
        tick(segs[k].lvl, got, want);
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL random step %0d: got %h want %h", n - 1, got, want);
        end
      end
    vectors++;
    if (valid_seen !== 1 + ok || err_seen !== 4 - ok) begin
      miscompares++;
      $display("FAIL random_totals: valids=%0d errs=%0d, want %0d %0d",
               valid_seen, err_seen, 1 + ok, 4 - ok);
    end
  endtask

  initial begin
    test_reset();
    test_lock_1024();
    test_full_scale_then_stuck_high();
    test_stuck_low_from_reset();
    test_tolerance();
    test_glitch();
    test_reset_while_locked();
    test_random_periods();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
